// File: rtl/lane_queue_sensor.sv
// Eight-lane queue occupancy tracker with timed departures on green and a
// single-request emergency arbiter that holds a lane until it is empty and green.
module lane_queue_sensor #(
  parameter int DEPART_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  carArrive,
  input  logic [7:0]  emgArrive,
  input  logic [7:0]  trafficLightOutput,
  output logic [63:0] lanes,
  output logic        emgSignal,
  output logic [7:0]  emgLane,
  output logic [7:0]  overflow
);

  localparam logic [3:0] LAST = 4'(DEPART_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ALERT, CLEAR} emgState_t;

  emgState_t   state, stateNext;
  logic [3:0]  count [8];
  logic [3:0]  countNext [8];
  logic [3:0]  timer [8];
  logic [3:0]  timerNext [8];
  logic [7:0]  arrive, depart;
  logic [7:0]  pending, pendingNext;
  logic [7:0]  servedLane, servedNext;
  logic        again, againNext;
  logic [7:0]  overflowNext;
  logic [63:0] lanesNext;
  logic [3:0]  selCount;
  logic        selGreen;
  logic [7:0]  request;

  function automatic logic [7:0] thermo(input logic [3:0] c);
    return 8'((9'd1 << c) - 9'd1);
  endfunction

  function automatic logic [7:0] lowestOne(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  assign arrive  = carArrive | emgArrive;
  assign request = pending | emgArrive;

  always_comb begin
    depart = '0;
    for (int k = 0; k < 8; k++)
      depart[k] = trafficLightOutput[k] && (timer[k] == LAST) && (count[k] != 4'd0);
  end

  // Per-lane occupancy and departure timer
  always_comb begin
    overflowNext = overflow;
    lanesNext    = '0;
    for (int k = 0; k < 8; k++) begin
      countNext[k] = count[k];
      timerNext[k] = 4'd0;
      if (trafficLightOutput[k]) begin
        if (timer[k] == LAST)
          timerNext[k] = depart[k] ? 4'd0 : LAST;
        else
          timerNext[k] = 4'(timer[k] + 4'd1);
      end
      if (arrive[k] && !depart[k]) begin
        if (count[k] == 4'd8)
          overflowNext[k] = 1'b1;
        else
          countNext[k] = 4'(count[k] + 4'd1);
      end else if (depart[k] && !arrive[k]) begin
        countNext[k] = 4'(count[k] - 4'd1);
      end
      lanesNext[8*k +: 8] = thermo(countNext[k]);
    end
  end

  always_comb begin
    selCount = 4'd0;
    for (int k = 0; k < 8; k++)
      if (servedLane[k]) selCount = count[k];
    selGreen = |(servedLane & trafficLightOutput);
  end

  // Emergency arbiter: a re-arrival on the lane in service is remembered in
  // 'again' so the served bit is restored instead of cleared at CLEAR.
  always_comb begin
    stateNext   = state;
    servedNext  = servedLane;
    pendingNext = pending | emgArrive;
    againNext   = again;
    case (state)
      IDLE: begin
        againNext = 1'b0;
        if (|request) begin
          servedNext = lowestOne(request);
          stateNext  = ALERT;
        end
      end
      ALERT: begin
        if (|(emgArrive & servedLane)) againNext = 1'b1;
        if (selCount == 4'd0 && selGreen) stateNext = CLEAR;
      end
      CLEAR: begin
        pendingNext = (pending & ~servedLane) | emgArrive | (again ? servedLane : 8'd0);
        againNext   = 1'b0;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      servedLane <= '0;
      again      <= 1'b0;
      overflow   <= '0;
      lanes      <= '0;
      emgSignal  <= 1'b0;
      emgLane    <= '0;
      for (int k = 0; k < 8; k++) begin
        count[k] <= 4'd0;
        timer[k] <= 4'd0;
      end
    end else begin
      state      <= stateNext;
      pending    <= pendingNext;
      servedLane <= servedNext;
      again      <= againNext;
      overflow   <= overflowNext;
      lanes      <= lanesNext;
      emgSignal  <= (stateNext == ALERT);
      emgLane    <= (stateNext == ALERT) ? servedNext : 8'd0;
      for (int k = 0; k < 8; k++) begin
        count[k] <= countNext[k];
        timer[k] <= timerNext[k];
      end
    end
  end

endmodule

// File: tb/tb_lane_queue_sensor.sv
// Vector-table bench for lane_queue_sensor: expected outputs are queued when a
// vector is driven and popped when the registered outputs are sampled.
module tb_lane_queue_sensor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  carArrive = '0, emgArrive = '0, trafficLightOutput = '0;
  logic [63:0] lanes;
  logic        emgSignal;
  logic [7:0]  emgLane, overflow;

  lane_queue_sensor #(.DEPART_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .carArrive(carArrive), .emgArrive(emgArrive),
    .trafficLightOutput(trafficLightOutput), .lanes(lanes),
    .emgSignal(emgSignal), .emgLane(emgLane), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name; logic [7:0] car, emg, green;
    logic [63:0] lanes; logic sig; logic [7:0] lane, ovf;
  } vecT;
  typedef struct {
    string name; logic [63:0] lanes; logic sig; logic [7:0] lane, ovf;
  } expT;

  vecT vecs[$];
  expT expQ[$];
  int  applied = 0;
  int  miscompares = 0;

  function automatic logic [63:0] occ(int lane, int n);
    logic [63:0] t;
    t = (64'd1 << n) - 64'd1;
    return t << (8 * lane);
  endfunction

  task automatic add(string name, logic [7:0] car, logic [7:0] emg, logic [7:0] green,
                     logic [63:0] l, logic sig, logic [7:0] lane, logic [7:0] ovf);
    vecT v;
    v.name = name; v.car = car; v.emg = emg; v.green = green;
    v.lanes = l; v.sig = sig; v.lane = lane; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic expectOut(string name, logic [63:0] l, logic sig, logic [7:0] lane, logic [7:0] ovf);
    expT e;
    e.name = name; e.lanes = l; e.sig = sig; e.lane = lane; e.ovf = ovf;
    expQ.push_back(e);
  endtask

  task automatic checkOut();
    expT e;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = expQ.pop_front();
    applied++;
    if (lanes !== e.lanes || emgSignal !== e.sig || emgLane !== e.lane || overflow !== e.ovf) begin
      miscompares++;
      $display("FAIL %s: got lanes=%h sig=%b emgLane=%b ovf=%b, expected lanes=%h sig=%b emgLane=%b ovf=%b",
               e.name, lanes, emgSignal, emgLane, overflow, e.lanes, e.sig, e.lane, e.ovf);
    end
  endtask

  task automatic runVecs();
    foreach (vecs[i]) begin
      carArrive          = vecs[i].car;
      emgArrive          = vecs[i].emg;
      trafficLightOutput = vecs[i].green;
      expectOut(vecs[i].name, vecs[i].lanes, vecs[i].sig, vecs[i].lane, vecs[i].ovf);
      @(posedge clk);
      #1;
      checkOut();
    end
    vecs.delete();
  endtask

  task automatic doReset(string name);
    carArrive = '0; emgArrive = '0; trafficLightOutput = '0;
    rst = 1'b1;
    #2;
    expectOut(name, '0, 1'b0, '0, '0);
    checkOut();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    doReset("resetState");

    // Fill lane 5 on red past capacity; overflow is sticky
    for (int i = 1; i <= 10; i++)
      add("fill", 8'h20, 8'h00, 8'h00, occ(5, (i > 8) ? 8 : i), 1'b0, 8'h00, (i >= 9) ? 8'h20 : 8'h00);
    add("fillIdle", 8'h00, 8'h00, 8'h00, occ(5, 8), 1'b0, 8'h00, 8'h20);
    runVecs();
    doReset("resetAfterFill");

    // Drain lane 1 from 3 cars, then saturated timer with a late arrival
    for (int i = 1; i <= 3; i++)
      add("load1", 8'h02, 8'h00, 8'h00, occ(1, i), 1'b0, 8'h00, 8'h00);
    begin
      int drainSeq[8] = '{3, 2, 2, 1, 1, 0, 0, 0};
      foreach (drainSeq[i])
        add("drain", 8'h00, 8'h00, 8'h02, occ(1, drainSeq[i]), 1'b0, 8'h00, 8'h00);
    end
    add("satArrive", 8'h02, 8'h00, 8'h02, occ(1, 1), 1'b0, 8'h00, 8'h00);
    add("satDepart", 8'h00, 8'h00, 8'h02, occ(1, 0), 1'b0, 8'h00, 8'h00);
    // Lane 0 at 4 cars: arrival coincident with departure holds the count
    for (int i = 1; i <= 4; i++)
      add("load0", 8'h01, 8'h00, 8'h00, occ(0, i), 1'b0, 8'h00, 8'h00);
    for (int r = 0; r < 2; r++) begin
      add("simTimer", 8'h00, 8'h00, 8'h01, occ(0, 4), 1'b0, 8'h00, 8'h00);
      add("simBoth",  8'h01, 8'h00, 8'h01, occ(0, 4), 1'b0, 8'h00, 8'h00);
    end
    add("depTimer", 8'h00, 8'h00, 8'h01, occ(0, 4), 1'b0, 8'h00, 8'h00);
    add("depOnly",  8'h00, 8'h00, 8'h01, occ(0, 3), 1'b0, 8'h00, 8'h00);
    runVecs();
    doReset("resetAfterDrain");

    // Single emergency on lane 3 (car and emergency together add one car)
    add("emgIn",     8'h08, 8'h08, 8'h00, occ(3, 1), 1'b1, 8'h08, 8'h00);
    add("alertHold", 8'h00, 8'h00, 8'h00, occ(3, 1), 1'b1, 8'h08, 8'h00);
    add("emgG1",     8'h00, 8'h00, 8'h08, occ(3, 1), 1'b1, 8'h08, 8'h00);
    add("emgG2",     8'h00, 8'h00, 8'h08, occ(3, 0), 1'b1, 8'h08, 8'h00);
    add("emgClear",  8'h00, 8'h00, 8'h08, '0, 1'b0, 8'h00, 8'h00);
    add("emgIdle",   8'h00, 8'h00, 8'h08, '0, 1'b0, 8'h00, 8'h00);
    add("emgQuiet",  8'h00, 8'h00, 8'h00, '0, 1'b0, 8'h00, 8'h00);
    runVecs();
    doReset("resetAfterEmg");

    // Two simultaneous requests, then a re-arrival on the lane in service
    add("prio",    8'h00, 8'h84, 8'h00, occ(2, 1) | occ(7, 1), 1'b1, 8'h04, 8'h00);
    add("prioG1",  8'h00, 8'h00, 8'h04, occ(2, 1) | occ(7, 1), 1'b1, 8'h04, 8'h00);
    add("prioG2",  8'h00, 8'h00, 8'h04, occ(7, 1), 1'b1, 8'h04, 8'h00);
    add("prioClr", 8'h00, 8'h00, 8'h04, occ(7, 1), 1'b0, 8'h00, 8'h00);
    add("prioIdl", 8'h00, 8'h00, 8'h04, occ(7, 1), 1'b0, 8'h00, 8'h00);
    add("prioNxt", 8'h00, 8'h00, 8'h04, occ(7, 1), 1'b1, 8'h80, 8'h00);
    add("reEmg",   8'h00, 8'h80, 8'h00, occ(7, 2), 1'b1, 8'h80, 8'h00);
    add("reG1",    8'h00, 8'h00, 8'h80, occ(7, 2), 1'b1, 8'h80, 8'h00);
    add("reG2",    8'h00, 8'h00, 8'h80, occ(7, 1), 1'b1, 8'h80, 8'h00);
    add("reG3",    8'h00, 8'h00, 8'h80, occ(7, 1), 1'b1, 8'h80, 8'h00);
    add("reG4",    8'h00, 8'h00, 8'h80, occ(7, 0), 1'b1, 8'h80, 8'h00);
    add("reClr",   8'h00, 8'h00, 8'h80, '0, 1'b0, 8'h00, 8'h00);
    add("reIdle",  8'h00, 8'h00, 8'h80, '0, 1'b0, 8'h00, 8'h00);
    add("reAgain", 8'h00, 8'h00, 8'h80, '0, 1'b1, 8'h80, 8'h00);
    add("reClr2",  8'h00, 8'h00, 8'h80, '0, 1'b0, 8'h00, 8'h00);
    add("reIdle2", 8'h00, 8'h00, 8'h80, '0, 1'b0, 8'h00, 8'h00);
    add("reQuiet", 8'h00, 8'h00, 8'h80, '0, 1'b0, 8'h00, 8'h00);
    runVecs();
    doReset("resetAfterPrio");

    // Reset asserted between edges while in ALERT with a departure timer running
    add("midEmg", 8'h00, 8'h01, 8'h00, occ(0, 1), 1'b1, 8'h01, 8'h00);
    add("midG1",  8'h00, 8'h00, 8'h01, occ(0, 1), 1'b1, 8'h01, 8'h00);
    runVecs();
    rst = 1'b1;
    #2;
    expectOut("rstMidAlert", '0, 1'b0, 8'h00, 8'h00);
    checkOut();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      add("postRst", 8'h00, 8'h00, 8'h01, '0, 1'b0, 8'h00, 8'h00);
    runVecs();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_queue_sensor.md
LANE_QUEUE_SENSOR -- requirements
Module: lane_queue_sensor

Interface
REQ-001 Parameter DEPART_CYCLES, default 2: clock cycles of continuous green per car departure; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 carArrive  input  8  bit k high for one cycle adds one car to lane k.
REQ-005 emgArrive  input  8  bit k high for one cycle adds one emergency vehicle to lane k.
REQ-006 trafficLightOutput  input  8  bit k = 1 means lane k is green.
REQ-007 lanes  output  64  lane k occupancy at lanes[8k+7:8k], thermometer code; lane order k=7..0 is w1,w2,s1,s2,e1,e2,n1,n2.
REQ-008 emgSignal  output  1  emergency request to the controller.
REQ-009 emgLane  output  8  one-hot lane of the active emergency; 0 when none.
REQ-010 overflow  output  8  sticky flag per lane: an arrival was dropped.

Function
REQ-011 Each lane SHALL keep a 4-bit count 0..8; lanes field = (1<<count)-1 (count 0 -> 00000000, count 8 -> 11111111).
REQ-012 All outputs SHALL be registered; an arrival at edge t SHALL appear on lanes after edge t.
REQ-013 Arrival per lane per cycle = carArrive[k] | emgArrive[k]; both high in one cycle SHALL add exactly one car.
REQ-014 Each lane SHALL have a depart timer; it clears to 0 on any cycle the lane is red.
REQ-015 While green, the timer SHALL increment; when timer = DEPART_CYCLES-1 and count > 0, one car SHALL depart and the timer SHALL return to 0.
REQ-016 While green with count = 0, the timer SHALL saturate at DEPART_CYCLES-1; an arrival then departs on the next such cycle.
REQ-017 Arrival and departure in the same cycle SHALL leave count unchanged.
REQ-018 An arrival at count 8 with no simultaneous departure SHALL be dropped and SHALL set overflow[k]; overflow clears only on reset.
REQ-019 count SHALL never go below 0 or above 8.
REQ-020 emgArrive[k] SHALL set pending[k], even when the car itself is dropped; re-arrival on a pending lane has no further effect on pending.
REQ-021 An emergency FSM SHALL have states IDLE, ALERT, CLEAR.
REQ-022 IDLE: emgSignal=0, emgLane=0; if any pending bit is set, latch the lowest-index pending lane into emgLane and go to ALERT.
REQ-023 ALERT: emgSignal=1, emgLane held; go to CLEAR when that lane's count = 0 and its green bit = 1 in the same cycle.
REQ-024 CLEAR (one cycle): emgSignal=0, emgLane=0; clear the served pending bit; return to IDLE.
REQ-025 A new emgArrive on the lane being served in ALERT SHALL stay pending and be served again after CLEAR.
REQ-026 Other lanes' pending bits SHALL wait; the minimum gap between two requests SHALL be 2 cycles (CLEAR, IDLE).

Reset
REQ-027 rst high SHALL immediately force: all counts, timers and pending bits to 0; lanes=0; overflow=0; emgSignal=0; emgLane=0; FSM=IDLE.
REQ-028 Reset asserted mid-ALERT or mid-departure SHALL discard all state; no departure or request survives reset.

Verification
REQ-029 Fill/drop: red on all lanes, carArrive[5] high 10 cycles -> lanes[47:40]=11111111, overflow=00100000.
REQ-030 Drain: lane 1 count 3, trafficLightOutput=00000010, DEPART_CYCLES=2 -> lanes[15:8] goes 00000111 -> 00000011 -> 00000001 -> 00000000, one step every 2 cycles, first step 2 cycles after green.
REQ-031 Simultaneous: lane 0 count 4, green, carArrive[0] held high -> lanes[7:0] stays 00001111.
REQ-032 Emergency: emgArrive=00001000 one cycle with lane 3 empty -> next cycle emgSignal=1, emgLane=00001000; green lane 3 -> after one departure, CLEAR cycle with emgSignal=0, then IDLE.
REQ-033 Priority: emgArrive=10000100 together -> emgLane=00000100 served first; after CLEAR and IDLE, emgLane=10000000.
REQ-034 Reset mid-ALERT: rst pulsed while emgSignal=1 -> emgSignal=0, emgLane=0 and lanes=0 the same cycle without a clock edge; no request after rst falls.
